pc_next_unit: RTL and testbench
===============================

// Module: pc_next_unit
// PURPOSE
//  Program-counter register and next-PC selector for the MIPS32 datapath.
//  Consumes the word-aligned branch offset from the offset shift-left stage,
//  the branch/jump decisions, and the pipeline stall. Drives the instruction-
//  memory fetch address with a valid/ready handshake.
//  Redirects that arrive during a stall are buffered so none is lost.
// PARAMETERS
//  WIDTH     32    datapath/PC width in bits; must be >= 29
//  RESET_PC  0     PC value loaded on reset; must be a multiple of 4
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  stall        in   1      hazard stall; 1 = hold PC, do not advance
//  branch_en    in   1      a branch instruction is resolved this cycle
//  branch_cond  in   1      branch condition (ALU zero, already polarity-adjusted)
//  offset_sh    in   WIDTH  sign-extended branch offset, already shifted left
//  jump_en      in   1      a J-type jump is resolved this cycle
//  jump_idx     in   26     instr_index field of the jump
//  fetch_ready  in   1      instruction memory accepts the address this cycle
//  pc           out  WIDTH  current fetch address
//  pc_plus4     out  WIDTH  pc + 4 (combinational from pc)
//  fetch_valid  out  1      pc is a valid fetch request
//  redirect     out  1      1-cycle pulse: a non-sequential PC was loaded
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pc=RESET_PC, fetch_valid=0, redirect=0, pending buffer cleared.
//   - state=BOOT. This takes effect mid-operation too; any pending redirect is discarded.
//  Targets (all modulo 2^WIDTH, carries dropped):
//   - br_tgt = pc_plus4 + offset_sh
//   - jmp_tgt = {pc_plus4[WIDTH-1:28], jump_idx, 2'b00}
//   - taken = jump_en | (branch_en & branch_cond)
//   - Priority: jump_en > taken branch > sequential. Both asserted -> jmp_tgt.
//  advance = fetch_valid & fetch_ready & ~stall.
//  States:
//   - BOOT: fetch_valid=0 for exactly one cycle after reset release, then go to RUN.
//     Redirect inputs in BOOT are ignored.
//   - RUN: fetch_valid=1.
//     - taken & ~stall: pc<=target, redirect=1 next cycle. The target is loaded even if
//       fetch_ready=0; it squashes the in-flight fetch.
//     - taken & stall: latch target into pend_pc, go to PEND; pc holds.
//     - ~taken & advance: pc<=pc_plus4.
//     - otherwise: hold.
//   - PEND: fetch_valid=1, pc holds.
//     - New taken while still stalled: overwrite pend_pc (latest wins).
//     - stall=0: pc<=pend_pc (or the new target if taken this cycle), redirect=1 next
//       cycle, go to RUN.
//  Latency:
//   - Redirect to a new pc: 1 cycle.
//   - Sequential advance: 1 cycle per accepted fetch.
//   - pc_plus4 has zero latency.
//  Boundaries:
//   - pc=2^WIDTH-4 wraps to 0 on sequential advance.
//   - Negative offset_sh gives a backward branch.
//   - Target equal to pc still pulses redirect.
//   - Only taken/pending transfers raise redirect; sequential advances never do.
// STRUCTURE
//  - Package mips_pc_pkg holds:
//    - state enum {BOOT, RUN, PEND};
//    - localparam INSTR_BYTES=4;
//    - localparam JIDX_W=26.
//  - Sub-module pc_target_calc (combinational) computes pc_plus4, br_tgt, jmp_tgt and
//    the priority-muxed target.
//  - This module holds pc, pend_pc, state and the redirect flop.
// TESTING
//  1. Reset release, fetch_ready=1, no branches
//     -> fetch_valid 0 for 1 cycle, then pc 0,4,8,C on consecutive cycles.
//  2. pc=0x40, branch_en=1, branch_cond=1, offset_sh=0xFFFFFFF0
//     -> next pc=0x34, redirect=1 for one cycle.
//  3. pc=0x0040_0010, jump_en=1 and branch taken together, jump_idx=0x100
//     -> next pc=0x0000_0400; the branch is ignored.
//  4. stall=1 for 3 cycles with a branch (tgt 0x80) then a jump (tgt 0x200) during it
//     -> pc holds; on stall release pc=0x200, redirect=1.
//  5. fetch_ready=0 for 2 cycles, no redirect -> pc holds; advances when ready returns.
//  6. rst_n low mid-PEND -> pc=RESET_PC immediately, pending target lost, BOOT re-entered.

Source files
------------

// File: rtl/mips_pc_pkg.sv
// Shared types and constants for the MIPS32 program-counter slice.
package mips_pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    PEND
  } pcState_e;

  localparam int INSTR_BYTES = 4;
  localparam int JIDX_W      = 26;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates: sequential, branch and jump targets,
// priority-muxed into a single target plus a "taken" flag.
module pc_target_calc
  import mips_pc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]  pc_i,
  input  logic [WIDTH-1:0]  offset_sh_i,
  input  logic [JIDX_W-1:0] jump_idx_i,
  input  logic              jump_en_i,
  input  logic              branch_en_i,
  input  logic              branch_cond_i,
  output logic [WIDTH-1:0]  pc_plus4_o,
  output logic [WIDTH-1:0]  target_o,
  output logic              taken_o
);

  logic [WIDTH-1:0] brTgt;
  logic [WIDTH-1:0] jmpTgt;
  logic             branchTaken;

  assign pc_plus4_o  = pc_i + WIDTH'(INSTR_BYTES);
  assign brTgt       = pc_plus4_o + offset_sh_i;
  // Jump keeps the upper region bits of the sequential address.
  assign jmpTgt      = {pc_plus4_o[WIDTH-1:JIDX_W+2], jump_idx_i, 2'b00};
  assign branchTaken = branch_en_i & branch_cond_i;
  assign taken_o     = jump_en_i | branchTaken;

  always_comb begin
    target_o = pc_plus4_o;
    if (jump_en_i) begin
      target_o = jmpTgt;
    end else if (branchTaken) begin
      target_o = brTgt;
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter register and next-PC selection with a one-deep buffer
// that holds a redirect arriving while the pipeline is stalled.
module pc_next_unit
  import mips_pc_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_en,
  input  logic              branch_cond,
  input  logic [WIDTH-1:0]  offset_sh,
  input  logic              jump_en,
  input  logic [JIDX_W-1:0] jump_idx,
  input  logic              fetch_ready,
  output logic [WIDTH-1:0]  pc,
  output logic [WIDTH-1:0]  pc_plus4,
  output logic              fetch_valid,
  output logic              redirect
);

  pcState_e         state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pendPc_q, pendPc_d;
  logic             redirect_q, redirect_d;

  logic [WIDTH-1:0] target;
  logic             taken;
  logic             advance;

  pc_target_calc #(
    .WIDTH(WIDTH)
  ) u_target (
    .pc_i          (pc_q),
    .offset_sh_i   (offset_sh),
    .jump_idx_i    (jump_idx),
    .jump_en_i     (jump_en),
    .branch_en_i   (branch_en),
    .branch_cond_i (branch_cond),
    .pc_plus4_o    (pc_plus4),
    .target_o      (target),
    .taken_o       (taken)
  );

  assign fetch_valid = (state_q != BOOT);
  assign advance     = fetch_valid & fetch_ready & ~stall;
  assign pc          = pc_q;
  assign redirect    = redirect_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pendPc_d   = pendPc_q;
    redirect_d = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        // A redirect squashes the in-flight fetch, so fetch_ready is not needed.
        if (taken && !stall) begin
          pc_d       = target;
          redirect_d = 1'b1;
        end else if (taken) begin
          pendPc_d = target;
          state_d  = PEND;
        end else if (advance) begin
          pc_d = pc_plus4;
        end
      end
      PEND: begin
        if (stall) begin
          if (taken) begin
            pendPc_d = target;
          end
        end else begin
          pc_d       = taken ? target : pendPc_q;
          redirect_d = 1'b1;
          state_d    = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pendPc_q   <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pendPc_q   <= pendPc_d;
      redirect_q <= redirect_d;
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed vector table, reset-in-PEND
// sequence and randomized traffic against a behavioural PC model.
module tb_pc_next_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_en;
  logic        branch_cond;
  logic [31:0] offset_sh;
  logic        jump_en;
  logic [25:0] jump_idx;
  logic        fetch_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        redirect;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic        stall;
    logic        branchEn;
    logic        branchCond;
    logic [31:0] offsetSh;
    logic        jumpEn;
    logic [25:0] jumpIdx;
    logic        fetchReady;
    logic [31:0] expPc;
    logic        expRedirect;
  } vec_t;

  vec_t vecs[$];

  pc_next_unit #(
    .WIDTH   (32),
    .RESET_PC(32'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .branch_en   (branch_en),
    .branch_cond (branch_cond),
    .offset_sh   (offset_sh),
    .jump_en     (jump_en),
    .jump_idx    (jump_idx),
    .fetch_ready (fetch_ready),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_valid (fetch_valid),
    .redirect    (redirect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic be, input logic bc,
                               input logic [31:0] off, input logic je,
                               input logic [25:0] ji, input logic fr);
    stall       = s;
    branch_en   = be;
    branch_cond = bc;
    offset_sh   = off;
    jump_en     = je;
    jump_idx    = ji;
    fetch_ready = fr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkVec(logic s, logic be, logic bc, logic [31:0] off,
                                 logic je, logic [25:0] ji, logic fr,
                                 logic [31:0] ePc, logic eRd);
    vec_t v;
    v.stall = s; v.branchEn = be; v.branchCond = bc; v.offsetSh = off;
    v.jumpEn = je; v.jumpIdx = ji; v.fetchReady = fr;
    v.expPc = ePc; v.expRedirect = eRd;
    return v;
  endfunction

  // Behavioural reference: where the program counter goes, given the
  // architectural rules (boot bubble, stall hold, one deferred redirect).
  logic        mBoot;
  logic        mHasPend;
  logic [31:0] mPendPc;
  logic [31:0] mPc;
  logic        mRedirect;

  task automatic modelStep(input logic s, input logic be, input logic bc,
                           input logic [31:0] off, input logic je,
                           input logic [25:0] ji, input logic fr);
    logic [31:0] seq;
    logic [31:0] dest;
    logic        transfer;
    seq      = mPc + 32'd4;
    transfer = je || (be && bc);
    if (je) dest = {seq[31:28], ji, 2'b00};
    else    dest = seq + off;
    mRedirect = 1'b0;
    if (mBoot) begin
      mBoot = 1'b0;
    end else if (s) begin
      if (transfer) begin
        mHasPend = 1'b1;
        mPendPc  = dest;
      end
    end else if (transfer || mHasPend) begin
      mPc       = transfer ? dest : mPendPc;
      mHasPend  = 1'b0;
      mRedirect = 1'b1;
    end else if (fr) begin
      mPc = seq;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 32'h0, 0, 26'h0, 0);

    // Directed table, starting from the first edge after reset release.
    vecs.push_back(mkVec(0, 0, 0, 32'h0,        1, 26'h55,     1, 32'h0,        0));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,        0, 26'h0,      1, 32'h4,        0));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,        0, 26'h0,      1, 32'h8,        0));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,        0, 26'h0,      1, 32'hC,        0));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,        1, 26'h10,     1, 32'h40,       1));
    vecs.push_back(mkVec(0, 1, 1, 32'hFFFFFFF0, 0, 26'h0,      1, 32'h34,       1));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,        0, 26'h0,      1, 32'h38,       0));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,        0, 26'h0,      0, 32'h38,       0));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,        0, 26'h0,      0, 32'h38,       0));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,        0, 26'h0,      1, 32'h3C,       0));
    vecs.push_back(mkVec(0, 1, 0, 32'h100,      0, 26'h0,      1, 32'h40,       0));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,        1, 26'h100004, 0, 32'h00400010, 1));
    vecs.push_back(mkVec(0, 1, 1, 32'h8,        1, 26'h100,    1, 32'h400,      1));
    vecs.push_back(mkVec(1, 1, 1, 32'hFFFFFC7C, 0, 26'h0,      1, 32'h400,      0));
    vecs.push_back(mkVec(1, 0, 0, 32'h0,        1, 26'h80,     1, 32'h400,      0));
    vecs.push_back(mkVec(1, 0, 0, 32'h0,        0, 26'h0,      1, 32'h400,      0));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,        0, 26'h0,      1, 32'h200,      1));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,        0, 26'h0,      1, 32'h204,      0));
    vecs.push_back(mkVec(0, 1, 1, 32'hFFFFFFFC, 0, 26'h0,      0, 32'h204,      1));
    vecs.push_back(mkVec(1, 0, 0, 32'h0,        0, 26'h0,      1, 32'h204,      0));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,        0, 26'h0,      1, 32'h208,      0));
    vecs.push_back(mkVec(0, 1, 1, 32'hFFFFFDF0, 0, 26'h0,      1, 32'hFFFFFFFC, 1));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,        0, 26'h0,      1, 32'h0,        0));
    vecs.push_back(mkVec(0, 1, 1, 32'hEFFFFFFC, 0, 26'h0,      1, 32'hF0000000, 1));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,        1, 26'h10,     1, 32'hF0000040, 1));

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_valid", {31'b0, fetch_valid}, 32'h0);
    checkOutput("reset_redirect", {31'b0, redirect}, 32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("boot_valid", {31'b0, fetch_valid}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].stall, vecs[i].branchEn, vecs[i].branchCond,
                    vecs[i].offsetSh, vecs[i].jumpEn, vecs[i].jumpIdx,
                    vecs[i].fetchReady);
      tick();
      checkOutput($sformatf("vec%0d_pc", i), pc, vecs[i].expPc);
      checkOutput($sformatf("vec%0d_pc4", i), pc_plus4, vecs[i].expPc + 32'd4);
      checkOutput($sformatf("vec%0d_valid", i), {31'b0, fetch_valid}, 32'h1);
      checkOutput($sformatf("vec%0d_redirect", i), {31'b0, redirect},
                  {31'b0, vecs[i].expRedirect});
    end

    // Reset while a redirect is pending: the target must be discarded.
    applyStimulus(1, 1, 1, 32'h100, 0, 26'h0, 1);
    tick();
    checkOutput("pend_hold_pc", pc, 32'hF0000040);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_pc", pc, 32'h0);
    checkOutput("midreset_valid", {31'b0, fetch_valid}, 32'h0);
    checkOutput("midreset_redirect", {31'b0, redirect}, 32'h0);
    tick();
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 32'h0, 0, 26'h0, 1);
    tick();
    checkOutput("reboot_pc", pc, 32'h0);
    checkOutput("reboot_valid", {31'b0, fetch_valid}, 32'h1);
    checkOutput("reboot_redirect", {31'b0, redirect}, 32'h0);
    tick();
    checkOutput("reboot_seq_pc", pc, 32'h4);
    checkOutput("reboot_seq_redirect", {31'b0, redirect}, 32'h0);

    // Randomized traffic against the reference model.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mBoot = 1'b1; mHasPend = 1'b0; mPendPc = '0; mPc = '0; mRedirect = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      logic        s, be, bc, je, fr;
      logic [31:0] off;
      logic [25:0] ji;
      s   = ($urandom_range(0, 99) < 30);
      be  = ($urandom_range(0, 99) < 20);
      bc  = $urandom_range(0, 1) == 1;
      je  = ($urandom_range(0, 99) < 8);
      fr  = ($urandom_range(0, 99) < 70);
      off = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFFFFFC)
                                        : (32'($signed($urandom_range(0, 255)) - 128) << 2);
      ji  = 26'($urandom());
      checkOutput("rnd_valid_pre", {31'b0, fetch_valid}, {31'b0, ~mBoot});
      applyStimulus(s, be, bc, off, je, ji, fr);
      modelStep(s, be, bc, off, je, ji, fr);
      tick();
      checkOutput("rnd_pc", pc, mPc);
      checkOutput("rnd_pc4", pc_plus4, mPc + 32'd4);
      checkOutput("rnd_redirect", {31'b0, redirect}, {31'b0, mRedirect});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
